pc_stack: RTL and testbench

- Parametrised program counter; successor to the 16-bit load/inc/reset PC.
- Adds configurable width, reset vector, stall, and a hardware call/return stack of configurable depth with overflow/underflow detection.
- Sits in the CPU fetch path and drives the instruction-memory address. The control decoder supplies in/load/call/ret.

---
 rtl/pc_stack.sv | 184 ++++++++++++++++++
 tb/tb_pc_stack.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//
// Program counter for the fetch path, with a hardware call/return stack.
// out drives the instruction-memory address. The control decoder supplies the
// load/inc/call/ret strobes and the jump/call target on `in`.
//
// One request is honoured on each rising edge. When several strobes are
// asserted together, the first match in this list wins:
//   reset > stall > ret > call > load > inc > hold
//
//   ret  : pop the top of the stack into out. If the stack is empty, out holds
//          and the sticky underflow flag is set.
//   call : push out+1 and jump to in. If the stack is full, the push is
//          dropped, the jump is still taken and the sticky overflow flag is
//          set.
//   load : out <= in.
//   inc  : out <= out + 1, wrapping modulo 2**WIDTH.
//
// Parameters
//   WIDTH     : width of the PC, the in bus and the stack entries
//   DEPTH     : number of return-stack entries (>= 1)
//   RESET_VEC : value that out takes on reset
//   CW        : width of depth_cnt (derived from DEPTH)
//
// Ports
//   clk       in   clock; all state changes on the rising edge
//   reset     in   synchronous active-high reset
//   in        in   jump/call target
//   load      in   jump request
//   inc       in   advance request
//   call      in   call request
//   ret       in   return request
//   stall     in   freeze the PC, the stack and the flags for this cycle
//   out       out  current PC (registered)
//   depth_cnt out  number of valid stack entries
//   full      out  depth_cnt == DEPTH
//   empty     out  depth_cnt == 0
//   overflow  out  sticky: a call arrived while the stack was full
//   underflow out  sticky: a ret arrived while the stack was empty
// -----------------------------------------------------------------------------
module pc_stack #(
  parameter int                WIDTH     = 16,
  parameter int                DEPTH     = 8,
  parameter logic [WIDTH-1:0]  RESET_VEC = '0,
  localparam int               CW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             inc,
  input  logic             call,
  input  logic             ret,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic [CW-1:0]    depth_cnt,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  // Width of a stack slot index. A one-entry stack still needs a 1-bit index.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0]    CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] PC_ONE   = WIDTH'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] out_q,       out_d;
  logic [CW-1:0]    depth_cnt_q, depth_cnt_d;
  logic             overflow_q,  overflow_d;
  logic             underflow_q, underflow_d;

  logic [WIDTH-1:0] stack_q [DEPTH];

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] pc_plus1;   // return address and inc target, mod 2**WIDTH
  logic [CW-1:0]    pop_cnt;    // depth after a pop
  logic [AW-1:0]    pop_idx;    // slot holding the top of the stack
  logic [AW-1:0]    push_idx;   // first free slot
  logic             is_full;
  logic             is_empty;

  logic             push_en;
  logic [WIDTH-1:0] push_data;

  assign pc_plus1 = out_q + PC_ONE;
  assign is_full  = (depth_cnt_q == CNT_FULL);
  assign is_empty = (depth_cnt_q == '0);

  // The count is always below DEPTH when a push is allowed, and above zero
  // when a pop is allowed. Dropping the upper count bit therefore loses no
  // information for either index.
  assign pop_cnt  = depth_cnt_q - CNT_ONE;
  assign pop_idx  = pop_cnt[AW-1:0];
  assign push_idx = depth_cnt_q[AW-1:0];

  // ---------------------------------------------------------------------------
  // Next-state logic: one priority chain decides the whole edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first. A path that
    // leaves one unassigned would infer a latch.
    out_d       = out_q;
    depth_cnt_d = depth_cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_en     = 1'b0;
    push_data   = pc_plus1;

    if (stall) begin
      // Everything holds. The other strobes are ignored.
    end else if (ret) begin
      if (is_empty) begin
        underflow_d = 1'b1;
      end else begin
        out_d       = stack_q[pop_idx];
        depth_cnt_d = pop_cnt;
      end
    end else if (call) begin
      // The jump is taken even when the return address cannot be saved.
      out_d = in;
      if (is_full) begin
        overflow_d = 1'b1;
      end else begin
        push_en     = 1'b1;
        depth_cnt_d = depth_cnt_q + CNT_ONE;
      end
    end else if (load) begin
      out_d = in;
    end else if (inc) begin
      out_d = pc_plus1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q       <= RESET_VEC;
      depth_cnt_q <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      depth_cnt_q <= depth_cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Stack storage
  // ---------------------------------------------------------------------------
  // NOTE: the stack array has no reset. Clearing depth_cnt empties the stack,
  // and an entry is never read before it has been written. A reset here
  // would only stop the array from mapping onto plain RAM.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      stack_q[push_idx] <= push_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign out       = out_q;
  assign depth_cnt = depth_cnt_q;
  assign full      = is_full;
  assign empty     = is_empty;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_pc_stack.sv
// -----------------------------------------------------------------------------
// tb_pc_stack
//
// Self-checking bench for pc_stack. Two instances share one set of inputs:
//   u_dut8 : DEPTH = 8, RESET_VEC = 16'h0100
//   u_dut2 : DEPTH = 2, RESET_VEC = 16'h0100 (for full/overflow corners)
//
// The reference model keeps the return stack as a queue and applies the
// priority rules directly. After every clock edge it is compared with both
// instances. The directed steps also check hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pc_stack;

  localparam logic [15:0] RV = 16'h0100;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        load  = 1'b0;
  logic        inc   = 1'b0;
  logic        call  = 1'b0;
  logic        ret   = 1'b0;
  logic        stall = 1'b0;
  logic [15:0] din   = '0;

  logic [15:0] o8, o2;
  logic [3:0]  dc8;
  logic [1:0]  dc2;
  logic        f8, e8, ov8, un8;
  logic        f2, e2, ov2, un2;

  pc_stack #(.WIDTH(16), .DEPTH(8), .RESET_VEC(RV)) u_dut8 (
    .clk(clk), .reset(reset), .in(din), .load(load), .inc(inc),
    .call(call), .ret(ret), .stall(stall), .out(o8), .depth_cnt(dc8),
    .full(f8), .empty(e8), .overflow(ov8), .underflow(un8)
  );

  pc_stack #(.WIDTH(16), .DEPTH(2), .RESET_VEC(RV)) u_dut2 (
    .clk(clk), .reset(reset), .in(din), .load(load), .inc(inc),
    .call(call), .ret(ret), .stall(stall), .out(o2), .depth_cnt(dc2),
    .full(f2), .empty(e2), .overflow(ov2), .underflow(un2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state. Index 0 mirrors u_dut8, index 1 mirrors u_dut2.
  logic [15:0] m_out [2];
  logic [15:0] m_q   [2][$];
  bit          m_ov  [2];
  bit          m_un  [2];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply the current inputs to one model instance.
  task automatic model_step(input int m, input int depth);
    if (reset) begin
      m_out[m] = RV;
      m_q[m].delete();
      m_ov[m] = 1'b0;
      m_un[m] = 1'b0;
    end else if (stall) begin
      // freeze
    end else if (ret) begin
      if (m_q[m].size() == 0) m_un[m] = 1'b1;
      else                    m_out[m] = m_q[m].pop_back();
    end else if (call) begin
      if (m_q[m].size() < depth) m_q[m].push_back(m_out[m] + 16'd1);
      else                       m_ov[m] = 1'b1;
      m_out[m] = din;
    end else if (load) begin
      m_out[m] = din;
    end else if (inc) begin
      m_out[m] = m_out[m] + 16'd1;
    end
  endtask

  task automatic compare_all();
    check("d8_out",   32'(o8),  32'(m_out[0]));
    check("d8_depth", 32'(dc8), 32'(m_q[0].size()));
    check("d8_full",  32'(f8),  32'(m_q[0].size() == 8));
    check("d8_empty", 32'(e8),  32'(m_q[0].size() == 0));
    check("d8_ovf",   32'(ov8), 32'(m_ov[0]));
    check("d8_unf",   32'(un8), 32'(m_un[0]));
    check("d2_out",   32'(o2),  32'(m_out[1]));
    check("d2_depth", 32'(dc2), 32'(m_q[1].size()));
    check("d2_full",  32'(f2),  32'(m_q[1].size() == 2));
    check("d2_empty", 32'(e2),  32'(m_q[1].size() == 0));
    check("d2_ovf",   32'(ov2), 32'(m_ov[1]));
    check("d2_unf",   32'(un2), 32'(m_un[1]));
  endtask

  // Drive one cycle of inputs, clock it, update the model, then compare
  // #1 after the edge.
  task automatic step(input bit r, input bit s, input bit rt, input bit c,
                      input bit l, input bit i, input logic [15:0] d);
    reset = r; stall = s; ret = rt; call = c; load = l; inc = i; din = d;
    @(posedge clk);
    model_step(0, 8);
    model_step(1, 2);
    #1;
    compare_all();
  endtask

  //                      r  s  rt c  l  i  din
  initial begin
    // ---- Reset and increment ------------------------------------------------
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    check("rst_out",   32'(o8),  32'h0100);
    check("rst_depth", 32'(dc8), 32'h0);
    check("rst_empty", 32'(e8),  32'h1);
    for (int k = 1; k <= 3; k++) begin
      step(0, 0, 0, 0, 0, 1, 16'h0000);
      check("inc_seq", 32'(o8), 32'h0100 + 32'(k));
    end
    step(0, 0, 0, 0, 1, 1, 16'hFFFF);          // load+inc: load wins
    check("load_over_inc", 32'(o8), 32'hFFFF);
    step(0, 0, 0, 0, 0, 1, 16'h0000);
    check("inc_wrap", 32'(o8), 32'h0000);

    // ---- Nested call / return -----------------------------------------------
    step(0, 0, 0, 0, 1, 0, 16'h0010);
    step(0, 0, 0, 1, 1, 1, 16'h0200);          // load/inc ignored under call
    check("call1_out", 32'(o8), 32'h0200);
    check("call1_dep", 32'(dc8), 32'h1);
    step(0, 0, 0, 1, 0, 0, 16'h0300);
    check("call2_out", 32'(o8), 32'h0300);
    check("call2_dep", 32'(dc8), 32'h2);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("ret1_out", 32'(o8), 32'h0201);
    check("ret1_dep", 32'(dc8), 32'h1);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("ret2_out", 32'(o8), 32'h0011);
    check("ret2_dep", 32'(dc8), 32'h0);

    // ---- Overflow / underflow on the 2-deep instance ------------------------
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 1, 0, 16'h0000);
    step(0, 0, 0, 1, 0, 0, 16'h0A00);          // pushes 0001
    step(0, 0, 0, 1, 0, 0, 16'h0B00);          // pushes 0A01, now full
    step(0, 0, 0, 1, 0, 0, 16'h0C00);          // push dropped
    check("ovf_out",  32'(o2),  32'h0C00);
    check("ovf_dep",  32'(dc2), 32'h2);
    check("ovf_full", 32'(f2),  32'h1);
    check("ovf_flag", 32'(ov2), 32'h1);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("ovf_ret1", 32'(o2), 32'h0A01);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("ovf_ret2", 32'(o2), 32'h0001);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("unf_hold", 32'(o2),  32'h0001);
    check("unf_flag", 32'(un2), 32'h1);
    check("ovf_stky", 32'(ov2), 32'h1);

    // ---- Priority -----------------------------------------------------------
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    step(0, 0, 0, 0, 1, 0, 16'h0054);
    step(0, 0, 0, 1, 0, 0, 16'h0099);          // pushes 0055
    step(0, 0, 1, 1, 1, 0, 16'h1234);          // ret wins over call and load
    check("pri_ret_out", 32'(o8),  32'h0055);
    check("pri_ret_dep", 32'(dc8), 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 1, 1, 1, 1, 16'h4321);
      check("stall_out", 32'(o8),  32'h0055);
      check("stall_unf", 32'(un8), 32'h0);
    end
    step(1, 1, 0, 0, 0, 0, 16'h0000);
    check("rst_over_stall", 32'(o8), 32'h0100);

    // ---- Reset in the middle of a call sequence -----------------------------
    step(0, 0, 0, 1, 0, 0, 16'h0300);
    step(0, 0, 0, 1, 0, 0, 16'h0400);
    step(0, 0, 0, 1, 0, 0, 16'h0500);          // overflows the 2-deep copy
    check("mid_dep", 32'(dc8), 32'h3);
    step(1, 0, 0, 0, 0, 0, 16'h0000);
    check("mid_rst_out", 32'(o8),  32'h0100);
    check("mid_rst_dep", 32'(dc8), 32'h0);
    check("mid_rst_ovf", 32'(ov2), 32'h0);
    step(0, 0, 1, 0, 0, 0, 16'h0000);
    check("mid_unf",     32'(un8), 32'h1);
    check("mid_unf_out", 32'(o8),  32'h0100);

    // ---- Random traffic against the model -----------------------------------
    for (int c = 0; c < 1000; c++) begin
      step((c == 10) || (c == 24) || (c == 44),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) == 0,
           $urandom_range(0, 6) == 0,
           $urandom_range(0, 1) == 0,
           ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
